// File: rtl/seg_display_mux.sv
// Multiplexed seven-segment driver: sequential double-dabble conversion into a display
// register, scanned across DIGITS active-low anodes. Optional macro: SEG_LZ_BLANK_EN.
module seg_display_mux #(
  parameter int DIGITS       = 4,
  parameter int VAL_W        = 14,
  parameter int REFRESH_BITS = 18
) (
  input  logic              clock_100Mhz,
  input  logic              reset,
  input  logic [VAL_W-1:0]  value,
  input  logic              load,
  output logic              busy,
  output logic [DIGITS-1:0] Anode_Activate,
  output logic [6:0]        SevenSegDisplay
);

  localparam int BW = DIGITS * 4;
  localparam int CW = $clog2(VAL_W + 1);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int k = 0; k < n; k++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] MAXV = pow10(DIGITS) - 64'd1;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'd0:    return 7'b0000001;
      4'd1:    return 7'b1001111;
      4'd2:    return 7'b0010010;
      4'd3:    return 7'b0000110;
      4'd4:    return 7'b1001100;
      4'd5:    return 7'b0100100;
      4'd6:    return 7'b0100000;
      4'd7:    return 7'b0001111;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0000100;
      default: return 7'b0000001;
    endcase
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
  state_t state_q, state_d;

  logic [VAL_W-1:0]        bin_q, bin_d;
  logic [BW-1:0]           bcd_q, bcd_d, adj;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    ovf_q, ovf_d;
  logic [BW-1:0]           disp_q, disp_d;
  logic                    dovf_q, dovf_d;
  logic [REFRESH_BITS-1:0] presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [DIGITS-1:0]       an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic [3:0]              nib;
  logic                    blk;

  always_ff @(posedge clock_100Mhz) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (load) state_d = S_SHIFT;
      S_SHIFT: if (cnt_q == CW'(VAL_W - 1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
  end

  // Converter datapath: add-3 correction precedes the joint left shift.
  always_comb begin
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    disp_d = disp_q;
    dovf_d = dovf_q;
    adj    = bcd_q;
    for (int k = 0; k < DIGITS; k++)
      if (bcd_q[k*4 +: 4] >= 4'd5) adj[k*4 +: 4] = bcd_q[k*4 +: 4] + 4'd3;
    case (state_q)
      S_IDLE: if (load) begin
        bin_d = value;
        bcd_d = '0;
        cnt_d = '0;
        ovf_d = 64'(value) > MAXV;
      end
      S_SHIFT: begin
        {bcd_d, bin_d} = {adj, bin_q} << 1;
        cnt_d          = cnt_q + CW'(1);
      end
      S_DONE: begin
        disp_d = bcd_q;
        dovf_d = ovf_q;
      end
      default: ;
    endcase
  end

  // Scan: index 0 is the most significant digit and drives the top anode bit.
  always_comb begin
    presc_d = presc_q + REFRESH_BITS'(1);
    idx_d   = idx_q;
    if (&presc_q) idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    nib  = '0;
    blk  = 1'b0;
    an_d = '1;
    for (int k = 0; k < DIGITS; k++)
      if (IW'(k) == idx_q) begin
        nib                = disp_q[(DIGITS-1-k)*4 +: 4];
        an_d[DIGITS-1-k]   = 1'b0;
      end
`ifdef SEG_LZ_BLANK_EN
    begin
      logic lead;
      lead = 1'b1;
      for (int k = 0; k < DIGITS - 1; k++) begin
        lead = lead & (disp_q[(DIGITS-1-k)*4 +: 4] == 4'd0);
        if (IW'(k) == idx_q) blk = lead;
      end
    end
`endif
    if (dovf_q)   seg_d = 7'b1111110;
    else if (blk) seg_d = 7'b1111111;
    else          seg_d = seg7(nib);
  end

  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      disp_q  <= '0;
      dovf_q  <= 1'b0;
      presc_q <= '0;
      idx_q   <= '0;
      an_q    <= '1;
      seg_q   <= 7'b1111111;
    end else begin
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      disp_q  <= disp_d;
      dovf_q  <= dovf_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign Anode_Activate  = an_q;
  assign SevenSegDisplay = seg_q;

endmodule

// File: tb/tb_seg_display_mux.sv
// Directed bench for seg_display_mux: a 4-digit and a 3-digit instance on one clock.
module tb_seg_display_mux;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ld, busy;
  logic [13:0] val;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        rst3, ld3, busy3;
  logic [9:0]  val3;
  logic [2:0]  an3;
  logic [6:0]  seg3;

  int total = 0;
  int bad   = 0;

`ifdef SEG_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010,
                         S3 = 7'b0000110, S4 = 7'b1001100, S5 = 7'b0100100,
                         S7 = 7'b0001111, S9 = 7'b0000100,
                         DASH = 7'b1111110, BL = 7'b1111111;

  seg_display_mux #(.DIGITS(4), .VAL_W(14), .REFRESH_BITS(4)) dut (
    .clock_100Mhz(clk), .reset(rst), .value(val), .load(ld), .busy(busy),
    .Anode_Activate(an), .SevenSegDisplay(seg));

  seg_display_mux #(.DIGITS(3), .VAL_W(10), .REFRESH_BITS(4)) dut3 (
    .clock_100Mhz(clk), .reset(rst3), .value(val3), .load(ld3), .busy(busy3),
    .Anode_Activate(an3), .SevenSegDisplay(seg3));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Wait (bounded) until the given digit is active, then check its segments.
  task automatic show(input bit three, input string tag, input int i, input logic [6:0] exp);
    logic [3:0] ea;
    logic [3:0] base;
    int n;
    base = three ? 4'b0100 : 4'b1000;
    ea   = ~(base >> i) & (three ? 4'b0111 : 4'b1111);
    n    = 0;
    while ((three ? {1'b0, an3} : an) !== ea && n < 200) begin tick(); n++; end
    if ((three ? {1'b0, an3} : an) !== ea)
      chk($sformatf("%s_an%0d", tag, i), three ? {1'b0, an3} : an, ea);
    else
      chk($sformatf("%s_d%0d", tag, i), three ? seg3 : seg, exp);
  endtask

  task automatic disp4(input string tag, input logic [6:0] e0, e1, e2, e3);
    show(1'b0, tag, 0, e0);
    show(1'b0, tag, 1, e1);
    show(1'b0, tag, 2, e2);
    show(1'b0, tag, 3, e3);
  endtask

  task automatic wait_idle(input bit three, output int n);
    n = 0;
    while ((three ? busy3 : busy) === 1'b1 && n < 100) begin n++; tick(); end
  endtask

  task automatic conv4(input logic [13:0] v, output int n);
    val = v; ld = 1'b1;
    tick();
    ld = 1'b0;
    wait_idle(1'b0, n);
    tick(2);
  endtask

  logic [3:0] seq4 [4];
  logic [2:0] seq3 [4];

  initial begin
    int n;
    seq4[0] = 4'b1011; seq4[1] = 4'b1101; seq4[2] = 4'b1110; seq4[3] = 4'b0111;
    seq3[0] = 3'b101;  seq3[1] = 3'b110;  seq3[2] = 3'b011;  seq3[3] = 3'b101;
    rst = 1'b1; rst3 = 1'b1; ld = 1'b0; ld3 = 1'b0; val = '0; val3 = '0;
    tick(3);
    chk("rst_an", an, 4'b1111);
    chk("rst_seg", seg, BL);
    chk("rst_busy", busy, 1'b0);
    chk("rst_an3", an3, 3'b111);
    chk("rst_seg3", seg3, BL);

    rst = 1'b0; rst3 = 1'b0;
    tick();
    chk("first_an", an, 4'b0111);
    chk("first_seg", seg, LZ ? BL : S0);
    chk("first_an3", an3, 3'b011);
    for (int s = 0; s < 4; s++) begin
      tick(16);
      chk($sformatf("scan_an_%0d", s), an, seq4[s]);
      chk($sformatf("scan_an3_%0d", s), an3, seq3[s]);
    end

    conv4(14'd1234, n);
    chk("busy_len_1234", n, 15);
    disp4("v1234", S1, S2, S3, S4);

    conv4(14'd10000, n);
    disp4("v10000", DASH, DASH, DASH, DASH);
    conv4(14'd9999, n);
    disp4("v9999", S9, S9, S9, S9);

    // Second load arrives mid-conversion and must be dropped.
    val = 14'd42; ld = 1'b1;
    tick();
    ld = 1'b0;
    tick(3);
    val = 14'd5678; ld = 1'b1;
    tick();
    ld = 1'b0;
    wait_idle(1'b0, n);
    tick(2);
    chk("busy_after_ignored", busy, 1'b0);
    disp4("v42", LZ ? BL : S0, LZ ? BL : S0, S4, S2);

    // Reset five cycles into a conversion discards it and clears the display.
    val = 14'd777; ld = 1'b1;
    tick();
    ld = 1'b0;
    tick(4);
    chk("busy_mid", busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", busy, 1'b0);
    tick(20);
    chk("abort_busy_late", busy, 1'b0);
    disp4("abort", LZ ? BL : S0, LZ ? BL : S0, LZ ? BL : S0, S0);

    conv4(14'd7, n);
    disp4("v7", LZ ? BL : S0, LZ ? BL : S0, LZ ? BL : S0, S7);
    conv4(14'd0, n);
    disp4("v0", LZ ? BL : S0, LZ ? BL : S0, LZ ? BL : S0, S0);
    conv4(14'd10000, n);
    disp4("v10000b", DASH, DASH, DASH, DASH);

    val3 = 10'd905; ld3 = 1'b1;
    tick();
    ld3 = 1'b0;
    wait_idle(1'b1, n);
    chk("busy_len_905", n, 11);
    tick(2);
    show(1'b1, "v905", 0, S9);
    show(1'b1, "v905", 1, S0);
    show(1'b1, "v905", 2, S5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
